// File: rtl/bank_frame_scheduler_if.sv
// Producer/consumer handshake bundle for bank_frame_scheduler.
//   in_valid/in_ready/in_data       : producer word stream into the scheduler
//   out_valid/out_ready/out_data    : consumer word stream out of the scheduler
//   out_last                        : marks the final word of a frame
// slave is the scheduler's view; master is the view of the environment driving it.
interface bank_frame_scheduler_if #(
    parameter int unsigned WORD_WIDTH = 4
) ();
    logic                  in_valid;
    logic                  in_ready;
    logic [WORD_WIDTH-1:0] in_data;
    logic                  out_valid;
    logic                  out_ready;
    logic [WORD_WIDTH-1:0] out_data;
    logic                  out_last;

    modport master (
        output in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_data, out_last
    );

    modport slave (
        input  in_valid, in_data, out_ready,
        output in_ready, out_valid, out_data, out_last
    );
endinterface

// File: rtl/bank_frame_scheduler.sv
// Runs a bankRAM as a circular buffer of frames (one frame per bank).
// The writer fills banks in rotating order; the reader streams complete banks
// out oldest-first through a 2-entry skid FIFO that absorbs the RAM read latency.
// Ports:
//   clk, rst_n          : clock, asynchronous active-low reset
//   bus (slave)         : producer in_* and consumer out_* handshakes
//   full_count          : banks holding complete, not yet freed frames
//   ram_wr_en           : per-bank write strobe (one-hot of write bank on accept)
//   ram_wr_bank_select  : one-hot current write bank
//   ram_rd_bank_select  : one-hot current read bank
//   ram_wr_address/data : write address and data (data = in_data)
//   ram_rd_address      : read address
//   ram_rd_data         : bankRAM read data, valid one cycle after address issue
module bank_frame_scheduler #(
    parameter int unsigned NO_BANKS      = 8,
    parameter int unsigned WORD_WIDTH    = 4,
    parameter int unsigned ADDRESS_WIDTH = 5
) (
    input  logic                           clk,
    input  logic                           rst_n,
    bank_frame_scheduler_if.slave          bus,
    output logic [$clog2(NO_BANKS+1)-1:0]  full_count,
    output logic [NO_BANKS-1:0]            ram_wr_en,
    output logic [NO_BANKS-1:0]            ram_wr_bank_select,
    output logic [NO_BANKS-1:0]            ram_rd_bank_select,
    output logic [ADDRESS_WIDTH-1:0]       ram_wr_address,
    output logic [ADDRESS_WIDTH-1:0]       ram_rd_address,
    output logic [WORD_WIDTH-1:0]          ram_wr_data,
    input  logic [WORD_WIDTH-1:0]          ram_rd_data
);
    localparam int unsigned PTR_W = (NO_BANKS > 1) ? $clog2(NO_BANKS) : 1;
    localparam int unsigned CNT_W = $clog2(NO_BANKS + 1);

    localparam logic [PTR_W-1:0]         LAST_BANK = PTR_W'(NO_BANKS - 1);
    localparam logic [ADDRESS_WIDTH-1:0] LAST_ADDR = '1;
    localparam logic [CNT_W-1:0]         ALL_FULL  = CNT_W'(NO_BANKS);

    typedef enum logic [1:0] {
        RD_IDLE   = 2'd0,
        RD_STREAM = 2'd1,
        RD_DRAIN  = 2'd2
    } rd_state_t;

    rd_state_t              rd_state;
    logic [PTR_W-1:0]       wr_ptr;
    logic [PTR_W-1:0]       rd_ptr;
    logic [ADDRESS_WIDTH-1:0] wr_addr;
    logic [ADDRESS_WIDTH-1:0] rd_addr;

    logic                   inflight;
    logic                   inflight_last;
    logic [1:0]             fifo_occ;
    logic [WORD_WIDTH-1:0]  fifo_data [2];
    logic [1:0]             fifo_last;

    logic                   accept;
    logic                   wr_done;
    logic                   pop;
    logic                   issue;
    logic                   free;
    logic [2:0]             slots_used;

    // Handshake and RAM-facing combinational outputs
    assign bus.in_ready  = (full_count != ALL_FULL);
    assign bus.out_valid = (fifo_occ != 2'd0);
    assign bus.out_data  = fifo_data[0];
    assign bus.out_last  = fifo_last[0];

    assign accept  = bus.in_valid & bus.in_ready;
    assign wr_done = accept & (wr_addr == LAST_ADDR);
    assign pop     = bus.out_valid & bus.out_ready;

    assign ram_wr_bank_select = NO_BANKS'(1) << wr_ptr;
    assign ram_rd_bank_select = NO_BANKS'(1) << rd_ptr;
    assign ram_wr_en          = accept ? ram_wr_bank_select : '0;
    assign ram_wr_address     = wr_addr;
    assign ram_rd_address     = rd_addr;
    assign ram_wr_data        = bus.in_data;

    // Slots committed next cycle: words held plus the word in flight, minus the
    // word leaving now. Counting the pop keeps one word per cycle under
    // continuous out_ready while still never overflowing the 2-entry FIFO.
    assign slots_used = 3'(fifo_occ) + 3'(inflight) - 3'(pop);
    assign issue      = (rd_state == RD_STREAM) && (slots_used < 3'd2);
    assign free       = (rd_state == RD_DRAIN) && pop && bus.out_last;

    // Write pointer/address: a bank rotates out once its last word is accepted
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr  <= '0;
            wr_addr <= '0;
        end else if (accept) begin
            wr_addr <= wr_addr + ADDRESS_WIDTH'(1);
            if (wr_addr == LAST_ADDR) begin
                wr_ptr <= (wr_ptr == LAST_BANK) ? '0 : wr_ptr + PTR_W'(1);
            end
        end
    end

    // Count of complete, unfreed frames; simultaneous fill and free cancel
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            full_count <= '0;
        end else begin
            case ({wr_done, free})
                2'b10:   full_count <= full_count + CNT_W'(1);
                2'b01:   full_count <= full_count - CNT_W'(1);
                default: full_count <= full_count;
            endcase
        end
    end

    // Read sequencer: stream the oldest full bank, then wait for its last pop
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_state <= RD_IDLE;
            rd_addr  <= '0;
            rd_ptr   <= '0;
        end else begin
            case (rd_state)
                RD_IDLE: begin
                    if (full_count != '0) begin
                        rd_state <= RD_STREAM;
                        rd_addr  <= '0;
                    end
                end
                RD_STREAM: begin
                    if (issue) begin
                        rd_addr <= rd_addr + ADDRESS_WIDTH'(1);
                        if (rd_addr == LAST_ADDR) begin
                            rd_state <= RD_DRAIN;
                        end
                    end
                end
                RD_DRAIN: begin
                    // Bank select moves only here, after every word of the bank has left
                    if (free) begin
                        rd_state <= RD_IDLE;
                        rd_ptr   <= (rd_ptr == LAST_BANK) ? '0 : rd_ptr + PTR_W'(1);
                    end
                end
                default: rd_state <= RD_IDLE;
            endcase
        end
    end

    // Read-return tracking and 2-entry output FIFO (entry 0 is the head)
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            inflight      <= 1'b0;
            inflight_last <= 1'b0;
            fifo_occ      <= 2'd0;
            fifo_data[0]  <= '0;
            fifo_data[1]  <= '0;
            fifo_last     <= 2'b00;
        end else begin
            inflight      <= issue;
            inflight_last <= issue && (rd_addr == LAST_ADDR);
            case ({inflight, pop})
                2'b10: begin
                    fifo_data[fifo_occ[0]] <= ram_rd_data;
                    fifo_last[fifo_occ[0]] <= inflight_last;
                    fifo_occ               <= fifo_occ + 2'd1;
                end
                2'b01: begin
                    fifo_data[0] <= fifo_data[1];
                    fifo_last[0] <= fifo_last[1];
                    fifo_occ     <= fifo_occ - 2'd1;
                end
                2'b11: begin
                    if (fifo_occ == 2'd1) begin
                        fifo_data[0] <= ram_rd_data;
                        fifo_last[0] <= inflight_last;
                    end else begin
                        fifo_data[0] <= fifo_data[1];
                        fifo_last[0] <= fifo_last[1];
                        fifo_data[1] <= ram_rd_data;
                        fifo_last[1] <= inflight_last;
                    end
                end
                default: begin
                    fifo_occ <= fifo_occ;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_bank_frame_scheduler.sv
// Self-checking bench for bank_frame_scheduler with a behavioural bankRAM and a
// frame-level reference model (word counters plus an expected-word queue).
module tb_bank_frame_scheduler;
    localparam int unsigned NB = 8;
    localparam int unsigned WW = 4;
    localparam int unsigned AW = 5;
    localparam int unsigned FL = 32;
    localparam int unsigned CW = $clog2(NB + 1);

    typedef struct packed {
        logic [WW-1:0] d;
        logic          l;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;

    bank_frame_scheduler_if #(.WORD_WIDTH(WW)) bus ();

    logic [CW-1:0] full_count;
    logic [NB-1:0] ram_wr_en;
    logic [NB-1:0] ram_wr_bank_select;
    logic [NB-1:0] ram_rd_bank_select;
    logic [AW-1:0] ram_wr_address;
    logic [AW-1:0] ram_rd_address;
    logic [WW-1:0] ram_wr_data;
    logic [WW-1:0] ram_rd_data;

    bank_frame_scheduler #(
        .NO_BANKS(NB), .WORD_WIDTH(WW), .ADDRESS_WIDTH(AW)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .bus(bus),
        .full_count(full_count),
        .ram_wr_en(ram_wr_en),
        .ram_wr_bank_select(ram_wr_bank_select),
        .ram_rd_bank_select(ram_rd_bank_select),
        .ram_wr_address(ram_wr_address),
        .ram_rd_address(ram_rd_address),
        .ram_wr_data(ram_wr_data),
        .ram_rd_data(ram_rd_data)
    );

    always #5 clk = ~clk;

    // Behavioural bankRAM: write on strobe, registered read from the selected bank
    logic [WW-1:0] mem [NB][FL];
    always @(posedge clk) begin
        for (int b = 0; b < NB; b++) begin
            if (ram_wr_en[b]) mem[b][ram_wr_address] <= ram_wr_data;
        end
        for (int b = 0; b < NB; b++) begin
            if (ram_rd_bank_select[b]) ram_rd_data <= mem[b][ram_rd_address];
        end
    end

    int n_checks = 0;
    int n_fail   = 0;

    function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual %0d required %0d (t=%0t)", name, act, exp, $time);
        end
    endfunction

    // Reference model state: words accepted / delivered since reset
    int   words_in  = 0;
    int   words_out = 0;
    exp_t exp_q [$];
    int   exp_fc;
    logic m_acc;
    logic m_pop;
    exp_t hd;
    logic stall_prev = 1'b0;
    logic [WW-1:0] prev_data;
    logic prev_last;
    logic align_pending = 1'b0;
    logic [CW-1:0] align_fc;

    // Compare process: sample mid-cycle, check, then advance the model past the edge
    always @(negedge clk) begin
        if (!rst_n) begin
            words_in      = 0;
            words_out     = 0;
            exp_q.delete();
            stall_prev    = 1'b0;
            align_pending = 1'b0;
            chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
            chk("rst_out_last", 32'(bus.out_last), 32'd0);
            chk("rst_full_count", 32'(full_count), 32'd0);
            chk("rst_in_ready", 32'(bus.in_ready), 32'd1);
            chk("rst_wr_en", 32'(ram_wr_en), 32'd0);
            chk("rst_rd_sel", 32'(ram_rd_bank_select), 32'd1);
            chk("rst_wr_sel", 32'(ram_wr_bank_select), 32'd1);
        end else begin
            exp_fc = (words_in / FL) - (words_out / FL);
            chk("full_count", 32'(full_count), 32'(exp_fc));
            chk("in_ready", 32'(bus.in_ready), 32'(exp_fc != NB));
            chk("rd_bank_sel", 32'(ram_rd_bank_select), 32'(NB'(1) << ((words_out / FL) % NB)));
            chk("wr_bank_sel", 32'(ram_wr_bank_select), 32'(NB'(1) << ((words_in / FL) % NB)));
            m_acc = bus.in_valid && (exp_fc != NB);
            chk("wr_en", 32'(ram_wr_en), m_acc ? 32'(NB'(1) << ((words_in / FL) % NB)) : 32'd0);
            if (m_acc) begin
                chk("wr_address", 32'(ram_wr_address), 32'(words_in % FL));
                chk("wr_data", 32'(ram_wr_data), 32'(bus.in_data));
            end
            if (align_pending) begin
                chk("align_full_count_hold", 32'(full_count), 32'(align_fc));
                align_pending = 1'b0;
            end
            if (stall_prev) begin
                chk("stall_out_valid", 32'(bus.out_valid), 32'd1);
                chk("stall_out_data", 32'(bus.out_data), 32'(prev_data));
                chk("stall_out_last", 32'(bus.out_last), 32'(prev_last));
            end
            m_pop = bus.out_valid && bus.out_ready;
            if (bus.out_valid) begin
                chk("out_before_frame_done", 32'(words_out < (words_in / FL) * FL), 32'd1);
            end
            if (m_pop) begin
                if (exp_q.size() == 0) begin
                    chk("pop_with_empty_model", 32'd1, 32'd0);
                end else begin
                    hd = exp_q.pop_front();
                    chk("out_data", 32'(bus.out_data), 32'(hd.d));
                    chk("out_last", 32'(bus.out_last), 32'(hd.l));
                end
            end
            if (m_acc && (words_in % FL == FL - 1) && m_pop && bus.out_last) begin
                align_pending = 1'b1;
                align_fc      = full_count;
            end
            if (m_acc) begin
                exp_q.push_back('{d: bus.in_data, l: (words_in % FL == FL - 1)});
                words_in++;
            end
            if (m_pop) words_out++;
            stall_prev = bus.out_valid && !bus.out_ready;
            prev_data  = bus.out_data;
            prev_last  = bus.out_last;
        end
    end

    // Offer one word until accepted; report the strobe and address seen at acceptance
    task automatic drive_word(input logic [WW-1:0] d, output logic [NB-1:0] en, output logic [AW-1:0] addr);
        int n = 0;
        bus.in_valid = 1'b1;
        bus.in_data  = d;
        #1;
        while (!bus.in_ready && n < 2000) begin
            @(posedge clk);
            #2;
            n++;
        end
        if (n >= 2000) chk("in_ready_timeout", 32'd0, 32'd1);
        en   = ram_wr_en;
        addr = ram_wr_address;
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
    endtask

    task automatic drain(input int limit);
        int n = 0;
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        while (words_out != words_in && n < limit) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk("drain_complete", 32'(words_out), 32'(words_in));
    endtask

    task automatic pulse_reset();
        bus.in_valid = 1'b0;
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    logic [NB-1:0] en;
    logic [AW-1:0] addr;
    int acc_n;
    int cyc;
    logic seen;

    initial begin
        bus.in_valid  = 1'b0;
        bus.in_data   = '0;
        bus.out_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // 1: single frame 0..15,0..15 through bank 0
        bus.out_ready = 1'b1;
        for (int i = 0; i < 32; i++) begin
            drive_word(WW'(i % 16), en, addr);
            if (i == 0) begin
                chk("t1_first_wr_en", 32'(en), 32'd1);
                chk("t1_first_addr", 32'(addr), 32'd0);
            end
        end
        chk("t1_full_count_after_write", 32'(full_count), 32'd1);
        drain(500);
        chk("t1_full_count_after_read", 32'(full_count), 32'd0);
        chk("t1_words_out", 32'(words_out), 32'd32);

        // 2: consumer stalled, buffer fills to all banks
        bus.out_ready = 1'b0;
        acc_n = 0;
        for (int i = 0; i < 300; i++) begin
            bus.in_valid = 1'b1;
            bus.in_data  = WW'($urandom);
            #1;
            if (bus.in_ready) acc_n++;
            @(posedge clk);
            #1;
        end
        bus.in_valid = 1'b0;
        chk("t2_accepted", 32'(acc_n), 32'd256);
        chk("t2_in_ready_low", 32'(bus.in_ready), 32'd0);
        chk("t2_full_count", 32'(full_count), 32'd8);
        bus.out_ready = 1'b1;
        cyc = 0;
        while (!bus.in_ready && cyc < 200) begin
            @(posedge clk);
            #1;
            cyc++;
        end
        chk("t2_in_ready_back", 32'(bus.in_ready), 32'd1);
        chk("t2_full_count_after_free", 32'(full_count), 32'd7);
        drain(3000);

        // 3: random valid/ready over 20 frames
        acc_n = 0;
        cyc = 0;
        while (acc_n < 640 && cyc < 20000) begin
            bus.in_valid  = ($urandom_range(0, 9) < 7);
            bus.in_data   = WW'($urandom);
            bus.out_ready = 1'($urandom_range(0, 1));
            #1;
            if (bus.in_valid && bus.in_ready) acc_n++;
            @(posedge clk);
            #1;
            cyc++;
        end
        chk("t3_accepted", 32'(acc_n), 32'd640);
        drain(3000);

        // 4: last write of one frame coincides with last pop of the previous
        bus.out_ready = 1'b0;
        for (int i = 0; i < 63; i++) drive_word(WW'($urandom), en, addr);
        bus.out_ready = 1'b1;
        seen = 1'b0;
        for (int c = 0; c < 200 && !seen; c++) begin
            if (bus.out_valid && bus.out_last) begin
                bus.in_valid = 1'b1;
                bus.in_data  = 4'h9;
                seen = 1'b1;
            end
            @(posedge clk);
            #1;
            bus.in_valid = 1'b0;
        end
        chk("t4_aligned", 32'(seen), 32'd1);
        chk("t4_full_count", 32'(full_count), 32'd1);
        drain(500);

        // 5: reset mid-frame with the reader mid-stream
        bus.out_ready = 1'b0;
        for (int i = 0; i < 32; i++) drive_word(WW'($urandom), en, addr);
        bus.out_ready = 1'b1;
        for (int i = 0; i < 12; i++) drive_word(WW'($urandom), en, addr);
        chk("t5_wr_addr", 32'(ram_wr_address), 32'd12);
        chk("t5_reader_midstream", 32'(words_out % FL != 0), 32'd1);
        rst_n = 1'b0;
        #1;
        chk("t5_rst_out_valid", 32'(bus.out_valid), 32'd0);
        chk("t5_rst_full_count", 32'(full_count), 32'd0);
        chk("t5_rst_in_ready", 32'(bus.in_ready), 32'd1);
        chk("t5_rst_wr_address", 32'(ram_wr_address), 32'd0);
        chk("t5_rst_rd_sel", 32'(ram_rd_bank_select), 32'd1);
        @(posedge clk);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        for (int i = 0; i < 32; i++) begin
            drive_word(WW'($urandom), en, addr);
            if (i == 0) begin
                chk("t5_first_wr_en", 32'(en), 32'd1);
                chk("t5_first_addr", 32'(addr), 32'd0);
            end
        end
        drain(500);

        // 6: nine frames from reset with a continuously ready consumer
        pulse_reset();
        bus.out_ready = 1'b1;
        for (int i = 0; i < 9 * 32; i++) begin
            drive_word(WW'($urandom), en, addr);
            if (i == 256) begin
                chk("t6_ninth_wr_en", 32'(en), 32'd1);
                chk("t6_ninth_addr", 32'(addr), 32'd0);
            end
        end
        drain(1000);
        chk("t6_words_out", 32'(words_out), 32'd288);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: time %0t reached limit 500000", $time);
        $fatal(1, "watchdog");
    end
endmodule
